mux3_rr_arbiter: RTL and testbench
==================================

// Module: mux3_rr_arbiter
// PURPOSE
//   Round-robin arbiter for three packet sources that share one n-bit 3:1 mux.
//   It sits directly upstream of the mux and drives its 2-bit select.
//   It grants one source for a whole packet, capped at MAX_BURST beats.
//   Handshake to the sink is valid/ready; gnt acks the owning source per beat.
// PARAMETERS
//   MAX_BURST  4  beats per grant before forced rotation (>=1; 1 = rotate every beat)
// PORTS
//   clk        in   1  single clock, all state on rising edge
//   rst_n      in   1  reset, asynchronous, active-low
//   req        in   3  req[i]=1: source i presents a beat
//   last       in   3  last[i]=1: source i's current beat ends its packet
//   out_ready  in   1  downstream accepts the mux output this cycle
//   sel        out  2  mux select: owner0=2'b00, owner1=2'b01, owner2=2'b10 (2'b11 never driven)
//   out_valid  out  1  mux output holds a valid beat
//   gnt        out  3  one-hot; gnt[i]=1 means source i's beat is consumed this cycle
//   busy       out  1  1 while in GRANT
// BEHAVIOUR
//   Reset (async, immediate on rst_n=0):
//   - state=IDLE, sel=2'b00, out_valid=0, gnt=0, busy=0.
//   - burst_cnt=0, last_owner=2, so source 0 has first priority.
//   State IDLE (arbitration, one cycle minimum):
//   - out_valid=0, gnt=0, sel holds its previous value.
//   - If req!=0, pick the first set req bit in order (last_owner+1)%3, +2, +3.
//   - Register owner and sel, clear burst_cnt, go to GRANT next cycle.
//   - If req==0, stay IDLE.
//   State GRANT:
//   - sel is constant, from owner.
//   - out_valid = req[owner]. busy=1.
//   - gnt[owner] = req[owner] & out_ready (combinational). Other gnt bits are 0.
//   - Beat transfer = out_valid & out_ready. Each transfer increments burst_cnt.
//   - Release (go to IDLE, last_owner<=owner) on a transfer where:
//     last[owner]=1, or burst_cnt+1==MAX_BURST.
//   - Otherwise stay in GRANT.
//   Boundary rules:
//   - Non-owner req/last bits are ignored in GRANT.
//   - Backpressure (out_ready=0): sel, out_valid and burst_cnt hold; gnt=0.
//   - req[owner] drops in GRANT: out_valid=0 (bubble), no transfer, grant kept.
//     Sources must hold req until their last beat.
//   - last and burst cap in the same beat: one release only; next arbitration is normal.
//   - Forced rotation mid-packet: the packet resumes on the source's next grant.
//     The sink sees interleaved beats. Packet reassembly is downstream's job.
//   - Re-arbitration always costs one IDLE cycle.
//     Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
//   - Width: burst_cnt is $clog2(MAX_BURST+1) bits and never wraps; it is cleared on grant.
//   - Round-robin pointer wraps 2 -> 0.
//   - Reset asserted in GRANT: returns to the reset values at once.
//     The partial burst is dropped; the source re-requests.
// TESTING
//   1. Rotation: reset, req=111, last=111, out_ready=1.
//      -> sel 00,01,10,00 on successive grants.
//      -> Each grant is 1 beat followed by 1 IDLE cycle. gnt 001,010,100,001.
//   2. Single packet: req=010, last[1] high on 3rd beat, out_ready=1.
//      -> 3 cycles sel=01, gnt=010, then IDLE. busy=0 one cycle after the 3rd beat.
//   3. Burst cap: MAX_BURST=4, req=011, last=000.
//      -> Owner0 for 4 beats, IDLE, owner1 for 4 beats, IDLE, owner0 again.
//   4. Backpressure: in GRANT after beat 2 of 5, out_ready=0 for 5 cycles.
//      -> sel and out_valid=1 stable, gnt=000, burst_cnt stays 2.
//      -> Remaining 3 beats complete after out_ready=1.
//   5. Reset mid-operation: rst_n=0 during owner1 GRANT.
//      -> sel=00, out_valid=0, gnt=0 in the same cycle.
//      -> After release, req=101 is granted to source 0 first.
//   6. Bubble: owner2 in GRANT, req[2]=0 for 2 cycles while req[0]=1.
//      -> out_valid=0, gnt=000, sel stays 10.
//      -> Grant is kept; it resumes when req[2]=1.

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner selection for three packet sources feeding one 3:1 mux.
// A grant lasts one packet or MAX_BURST beats, whichever ends first.
//   state    | meaning
//   ST_IDLE  | arbitrate; register owner/sel when any req is pending
//   ST_GRANT | owner streams beats to the sink under valid/ready
module mux3_rr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] last,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic [2:0] gnt,
  output logic       busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP_M1 = CW'(MAX_BURST - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic [1:0]    r_last_owner, w_last_owner_nxt;
  logic [CW-1:0] r_burst_cnt, w_burst_cnt_nxt;

  logic [1:0]    w_cand1, w_cand2, w_pick;
  logic          w_pick_vld;
  logic          w_valid, w_xfer;

  // Search order starts just after the previous owner and wraps 2 -> 0.
  assign w_cand1 = (r_last_owner == 2'd2) ? 2'd0 : r_last_owner + 2'd1;
  assign w_cand2 = (w_cand1 == 2'd2) ? 2'd0 : w_cand1 + 2'd1;

  always_comb begin
    w_pick     = r_last_owner;
    w_pick_vld = 1'b1;
    if (req[w_cand1])           w_pick = w_cand1;
    else if (req[w_cand2])      w_pick = w_cand2;
    else if (req[r_last_owner]) w_pick = r_last_owner;
    else                        w_pick_vld = 1'b0;
  end

  assign w_valid = (r_state == ST_GRANT) && req[r_owner];
  assign w_xfer  = w_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd2;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_burst_cnt_nxt  = r_burst_cnt;
    sel              = r_owner;
    out_valid        = w_valid;
    gnt              = 3'b000;
    busy             = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_owner_nxt     = w_pick;
          w_burst_cnt_nxt = '0;
          w_state_nxt     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        busy = 1'b1;
        if (w_xfer) begin
          gnt[r_owner]    = 1'b1;
          w_burst_cnt_nxt = r_burst_cnt + CW'(1);
          // Packet end and burst cap in the same beat still give one release.
          if (last[r_owner] || (r_burst_cnt == CAP_M1)) begin
            w_state_nxt      = ST_IDLE;
            w_last_owner_nxt = r_owner;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter: per-cycle vectors plus a beat scoreboard
// that pairs every observed grant with a hand-computed {sel, gnt} entry.
module tb_mux3_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] last;
  logic       out_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [2:0] gnt;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  string g_test = "reset";
  int g_cyc = 0;

  logic [4:0] exp_q[$];
  logic [4:0] m_exp;

  mux3_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .gnt       (gnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%s cyc %0d]: got %0h required %0h", name, g_test, g_cyc, act, exp);
  endtask

  task automatic push(input logic [1:0] s, input logic [2:0] g, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({s, g});
  endtask

  // Drive one cycle's inputs (called at posedge+1), check at negedge, advance.
  task automatic vec(input logic [2:0] r, input logic [2:0] l, input logic rdy,
                     input logic b, input logic ov, input logic [1:0] s);
    req = r; last = l; out_ready = rdy;
    @(negedge clk);
    chk("busy", {7'b0, busy}, {7'b0, b});
    chk("out_valid", {7'b0, out_valid}, {7'b0, ov});
    chk("sel", {6'b0, sel}, {6'b0, s});
    @(posedge clk); #1;
    g_cyc++;
  endtask

  task automatic start(input string name);
    g_test = name;
    g_cyc = 0;
  endtask

  // Scoreboard monitor: every consumed beat must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && gnt !== 3'b000) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_gnt [%s cyc %0d]: got sel=%0d gnt=%b required no beat",
                 g_test, g_cyc, sel, gnt);
      end else begin
        m_exp = exp_q.pop_front();
        chk("sb_beat", {3'b0, sel, gnt}, {3'b0, m_exp});
        chk("sb_valid", {7'b0, out_valid}, 8'h01);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req = 3'b000; last = 3'b000; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_sel", {6'b0, sel}, 8'h00);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_gnt", {5'b0, gnt}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    start("rotation");
    push(2'b00, 3'b001, 1); push(2'b01, 3'b010, 1);
    push(2'b10, 3'b100, 1); push(2'b00, 3'b001, 1);
    vec(3'b111, 3'b111, 1, 0, 0, 2'b00);
    vec(3'b111, 3'b111, 1, 1, 1, 2'b00);
    vec(3'b111, 3'b111, 1, 0, 0, 2'b00);
    vec(3'b111, 3'b111, 1, 1, 1, 2'b01);
    vec(3'b111, 3'b111, 1, 0, 0, 2'b01);
    vec(3'b111, 3'b111, 1, 1, 1, 2'b10);
    vec(3'b111, 3'b111, 1, 0, 0, 2'b10);
    vec(3'b111, 3'b111, 1, 1, 1, 2'b00);
    vec(3'b000, 3'b000, 1, 0, 0, 2'b00);

    start("single_packet");
    push(2'b01, 3'b010, 3);
    vec(3'b010, 3'b000, 1, 0, 0, 2'b00);
    vec(3'b010, 3'b000, 1, 1, 1, 2'b01);
    vec(3'b010, 3'b000, 1, 1, 1, 2'b01);
    vec(3'b010, 3'b010, 1, 1, 1, 2'b01);
    vec(3'b000, 3'b000, 1, 0, 0, 2'b01);

    start("burst_cap");
    push(2'b00, 3'b001, 4); push(2'b01, 3'b010, 4); push(2'b00, 3'b001, 1);
    vec(3'b011, 3'b000, 1, 0, 0, 2'b01);
    for (int i = 0; i < 4; i++) vec(3'b011, 3'b000, 1, 1, 1, 2'b00);
    vec(3'b011, 3'b001, 1, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) vec(3'b011, 3'b001, 1, 1, 1, 2'b01);
    vec(3'b011, 3'b001, 1, 0, 0, 2'b01);
    vec(3'b011, 3'b001, 1, 1, 1, 2'b00);
    vec(3'b000, 3'b000, 1, 0, 0, 2'b00);

    start("backpressure");
    push(2'b01, 3'b010, 5);
    vec(3'b010, 3'b000, 1, 0, 0, 2'b00);
    vec(3'b010, 3'b000, 1, 1, 1, 2'b01);
    vec(3'b010, 3'b000, 1, 1, 1, 2'b01);
    for (int i = 0; i < 5; i++) vec(3'b010, 3'b000, 0, 1, 1, 2'b01);
    vec(3'b010, 3'b000, 1, 1, 1, 2'b01);
    vec(3'b010, 3'b000, 1, 1, 1, 2'b01);
    vec(3'b010, 3'b010, 1, 0, 0, 2'b01);
    vec(3'b010, 3'b010, 1, 1, 1, 2'b01);
    vec(3'b000, 3'b000, 1, 0, 0, 2'b01);

    start("reset_mid");
    push(2'b01, 3'b010, 1);
    vec(3'b010, 3'b000, 1, 0, 0, 2'b01);
    vec(3'b010, 3'b000, 1, 1, 1, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("rstmid_sel", {6'b0, sel}, 8'h00);
    chk("rstmid_valid", {7'b0, out_valid}, 8'h00);
    chk("rstmid_gnt", {5'b0, gnt}, 8'h00);
    chk("rstmid_busy", {7'b0, busy}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(2'b00, 3'b001, 1); push(2'b10, 3'b100, 1);
    vec(3'b101, 3'b101, 1, 0, 0, 2'b00);
    vec(3'b101, 3'b101, 1, 1, 1, 2'b00);
    vec(3'b101, 3'b101, 1, 0, 0, 2'b00);
    vec(3'b101, 3'b101, 1, 1, 1, 2'b10);
    vec(3'b000, 3'b000, 1, 0, 0, 2'b10);

    start("bubble");
    push(2'b10, 3'b100, 2); push(2'b00, 3'b001, 1);
    vec(3'b100, 3'b000, 1, 0, 0, 2'b10);
    vec(3'b100, 3'b000, 1, 1, 1, 2'b10);
    vec(3'b001, 3'b000, 1, 1, 0, 2'b10);
    vec(3'b001, 3'b000, 1, 1, 0, 2'b10);
    vec(3'b101, 3'b100, 1, 1, 1, 2'b10);
    vec(3'b001, 3'b001, 1, 0, 0, 2'b10);
    vec(3'b001, 3'b001, 1, 1, 1, 2'b00);
    vec(3'b000, 3'b000, 1, 0, 0, 2'b00);
    vec(3'b000, 3'b000, 1, 0, 0, 2'b00);

    start("drain");
    chk("sb_leftover", exp_q.size() > 255 ? 8'hff : 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
